// File: rtl/int_exc_sequencer.sv
`default_nettype none
// ==== int_exc_sequencer : steers IF into interrupt (drain/push/vector) and exception (flush/jump) entry ====
// ==== rev 1.0 =============================================================================================
module int_exc_sequencer #(
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] INT_VEC_ADDR = 32'h0000_0000,
  parameter logic [31:0] EXC_HANDLER  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic        exception,
  input  logic [31:0] exc_pc,
  input  logic [31:0] resume_pc,
  output logic        push_req,
  output logic [15:0] push_data,
  input  logic        push_ack,
  output logic        vec_rd_req,
  output logic [31:0] vec_rd_addr,
  input  logic [15:0] vec_rd_data,
  input  logic        vec_rd_ack,
  output logic        stall,
  output logic        flush,
  output logic        jmp_sgn,
  output logic [31:0] PC_jmpValue,
  output logic [31:0] EPC,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    PUSH_HI = 3'd2,
    PUSH_LO = 3'd3,
    VEC_LO  = 3'd4,
    VEC_HI  = 3'd5,
    EXC_JMP = 3'd6,
    JUMP    = 3'd7
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      state, next_state;
  logic        int_prev, int_pend, exc_pend, rpc_held;
  logic [3:0]  cnt;
  logic [31:0] rpc, vec, exc_pc_lat;
  logic        int_edge, exc_take, int_take, preempt;

  assign int_edge = interrupt & ~int_prev;

  always_comb begin
    next_state  = state;
    exc_take    = 1'b0;
    int_take    = 1'b0;
    preempt     = 1'b0;
    stall       = 1'b0;
    push_req    = 1'b0;
    push_data   = 16'h0000;
    vec_rd_req  = 1'b0;
    vec_rd_addr = 32'h0000_0000;
    jmp_sgn     = 1'b0;
    PC_jmpValue = 32'h0000_0000;
    case (state)
      IDLE: begin
        if (exception || exc_pend) begin
          exc_take   = 1'b1;
          next_state = EXC_JMP;
        end else if (int_pend || int_edge) begin
          int_take   = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (exception) begin
          preempt    = 1'b1;
          next_state = EXC_JMP;
        end else if (cnt == 4'd0) begin
          next_state = PUSH_HI;
        end
      end
      PUSH_HI: begin
        stall     = 1'b1;
        push_req  = 1'b1;
        push_data = rpc[31:16];
        if (push_ack) next_state = PUSH_LO;
      end
      PUSH_LO: begin
        stall     = 1'b1;
        push_req  = 1'b1;
        push_data = rpc[15:0];
        if (push_ack) next_state = VEC_LO;
      end
      VEC_LO: begin
        stall       = 1'b1;
        vec_rd_req  = 1'b1;
        vec_rd_addr = INT_VEC_ADDR;
        if (vec_rd_ack) next_state = VEC_HI;
      end
      VEC_HI: begin
        stall       = 1'b1;
        vec_rd_req  = 1'b1;
        vec_rd_addr = INT_VEC_ADDR + 32'd1;
        if (vec_rd_ack) next_state = JUMP;
      end
      JUMP: begin
        jmp_sgn     = 1'b1;
        PC_jmpValue = vec;
        next_state  = IDLE;
      end
      EXC_JMP: begin
        jmp_sgn     = 1'b1;
        PC_jmpValue = EXC_HANDLER;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Flush is the only output tied to a live input; held low while reset is asserted.
    flush = reset & (exc_take | preempt);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      int_prev   <= 1'b0;
      int_pend   <= 1'b0;
      exc_pend   <= 1'b0;
      rpc_held   <= 1'b0;
      cnt        <= 4'd0;
      rpc        <= 32'h0000_0000;
      vec        <= 32'h0000_0000;
      exc_pc_lat <= 32'h0000_0000;
      EPC        <= 32'h0000_0000;
    end else begin
      state    <= next_state;
      int_prev <= interrupt;

      if (int_take)                 int_pend <= 1'b0;
      else if (preempt || int_edge) int_pend <= 1'b1;

      // A preempted interrupt keeps the resume PC it captured on first acceptance.
      if (int_take) begin
        rpc_held <= 1'b0;
        cnt      <= CNT_INIT;
        if (!rpc_held) rpc <= resume_pc;
      end else if (preempt) begin
        rpc_held <= 1'b1;
      end else if (state == DRAIN && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (exc_take) begin
        exc_pend <= 1'b0;
        EPC      <= exception ? exc_pc : exc_pc_lat;
      end else if (preempt) begin
        EPC <= exc_pc;
      end else if (exception && state != IDLE && state != DRAIN) begin
        exc_pend   <= 1'b1;
        exc_pc_lat <= exc_pc;
      end

      if (state == VEC_LO && vec_rd_ack) vec[15:0]  <= vec_rd_data;
      if (state == VEC_HI && vec_rd_ack) vec[31:16] <= vec_rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_exc_sequencer.sv
`default_nettype none
// Directed bench for int_exc_sequencer: interrupt entry, ack back-pressure, exceptions, preemption, reset abort.
module tb_int_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset, interrupt, exception, push_ack, vec_rd_ack;
  logic [31:0] exc_pc, resume_pc;
  logic        push_req, vec_rd_req, stall, flush, jmp_sgn, busy;
  logic [15:0] push_data, vec_rd_data;
  logic [31:0] vec_rd_addr, PC_jmpValue, EPC;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Vector memory: handler 32'h0000_0200 stored lo half at 0, hi half at 1.
  always_comb vec_rd_data = (vec_rd_addr == 32'h0) ? 16'h0200 : 16'h0000;

  int_exc_sequencer dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .exception(exception),
    .exc_pc(exc_pc), .resume_pc(resume_pc),
    .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
    .vec_rd_req(vec_rd_req), .vec_rd_addr(vec_rd_addr), .vec_rd_data(vec_rd_data),
    .vec_rd_ack(vec_rd_ack), .stall(stall), .flush(flush), .jmp_sgn(jmp_sgn),
    .PC_jmpValue(PC_jmpValue), .EPC(EPC), .busy(busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; interrupt = 1'b0; exception = 1'b0; push_ack = 1'b0; vec_rd_ack = 1'b0;
    exc_pc = 32'h0; resume_pc = 32'h0;

    // Reset state
    tick(2);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_jmp", {31'b0, jmp_sgn}, 32'h0);
    chk("rst_pcj", PC_jmpValue, 32'h0);
    chk("rst_epc", EPC, 32'h0);
    chk("rst_vaddr", vec_rd_addr, 32'h0);
    chk("rst_push", {31'b0, push_req}, 32'h0);
    reset = 1'b1;
    tick(1);

    // Interrupt with zero-wait acks; level then held high for more than 10 cycles
    interrupt = 1'b1; resume_pc = 32'h0000_0040; push_ack = 1'b1; vec_rd_ack = 1'b1;
    #1 chk("t2_stall_T", {31'b0, stall}, 32'h0);
    tick(1);
    chk("t2_stall_T1", {31'b0, stall}, 32'h1);
    chk("t2_busy", {31'b0, busy}, 32'h1);
    tick(3);
    chk("t2_drain4_push", {31'b0, push_req}, 32'h0);
    tick(1);
    chk("t2_push_hi_req", {31'b0, push_req}, 32'h1);
    chk("t2_push_hi", {16'h0, push_data}, 32'h0000);
    tick(1);
    chk("t2_push_lo", {16'h0, push_data}, 32'h0040);
    tick(1);
    chk("t2_vec_lo_req", {31'b0, vec_rd_req}, 32'h1);
    chk("t2_vec_lo_addr", vec_rd_addr, 32'h0);
    tick(1);
    chk("t2_vec_hi_addr", vec_rd_addr, 32'h1);
    tick(1);
    chk("t2_jmp", {31'b0, jmp_sgn}, 32'h1);
    chk("t2_pcj", PC_jmpValue, 32'h0000_0200);
    chk("t2_jmp_stall", {31'b0, stall}, 32'h0);
    tick(1);
    chk("t2_idle", {31'b0, busy}, 32'h0);
    chk("t2_jmp_off", {31'b0, jmp_sgn}, 32'h0);
    tick(10);
    chk("t6_level_once", {31'b0, busy}, 32'h0);
    interrupt = 1'b0;
    tick(1);

    // push_ack delayed 3 cycles
    push_ack = 1'b0; interrupt = 1'b1;
    tick(5);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_req", {31'b0, push_req}, 32'h1);
      chk("t3_hold_data", {16'h0, push_data}, 32'h0000);
      tick(1);
    end
    chk("t3_hold_req4", {31'b0, push_req}, 32'h1);
    push_ack = 1'b1;
    tick(1);
    chk("t3_push_lo", {16'h0, push_data}, 32'h0040);
    tick(3);
    chk("t3_jmp", {31'b0, jmp_sgn}, 32'h1);
    chk("t3_pcj", PC_jmpValue, 32'h0000_0200);
    tick(1);
    interrupt = 1'b0;
    tick(1);

    // Exception from IDLE
    exception = 1'b1; exc_pc = 32'h0000_0123;
    #1 chk("t4_flush", {31'b0, flush}, 32'h1);
    tick(1);
    exception = 1'b0;
    chk("t4_epc", EPC, 32'h0000_0123);
    chk("t4_jmp", {31'b0, jmp_sgn}, 32'h1);
    chk("t4_pcj", PC_jmpValue, 32'h0000_0100);
    chk("t4_nopush", {31'b0, push_req}, 32'h0);
    #1 chk("t4_flush_off", {31'b0, flush}, 32'h0);
    tick(1);
    chk("t4_idle", {31'b0, busy}, 32'h0);

    // Exception in DRAIN cycle 2 preempts; interrupt re-runs with the captured rpc
    interrupt = 1'b1; resume_pc = 32'h0000_1234;
    tick(2);
    exception = 1'b1; exc_pc = 32'h0000_0456;
    #1 chk("t5_flush", {31'b0, flush}, 32'h1);
    tick(1);
    exception = 1'b0; resume_pc = 32'h0000_9999;
    chk("t5_epc", EPC, 32'h0000_0456);
    chk("t5_pcj", PC_jmpValue, 32'h0000_0100);
    tick(1);
    chk("t5_back_idle", {31'b0, busy}, 32'h0);
    tick(1);
    chk("t5_redrain", {31'b0, stall}, 32'h1);
    tick(4);
    chk("t5_push_hi", {16'h0, push_data}, 32'h0000);
    tick(1);
    chk("t5_push_lo", {16'h0, push_data}, 32'h1234);
    tick(3);
    chk("t5_jmp_pcj", PC_jmpValue, 32'h0000_0200);
    tick(1);
    interrupt = 1'b0; resume_pc = 32'h0000_0040;
    tick(1);

    // Exception during VEC_LO is serviced right after JUMP
    interrupt = 1'b1;
    tick(7);
    chk("t6_in_vec_lo", {31'b0, vec_rd_req}, 32'h1);
    exception = 1'b1; exc_pc = 32'h0000_0777;
    #1 chk("t6_no_flush", {31'b0, flush}, 32'h0);
    tick(1);
    exception = 1'b0;
    chk("t6_epc_hold", EPC, 32'h0000_0456);
    tick(1);
    chk("t6_jmp_pcj", PC_jmpValue, 32'h0000_0200);
    tick(1);
    chk("t6_idle_busy", {31'b0, busy}, 32'h0);
    chk("t6_pend_flush", {31'b0, flush}, 32'h1);
    tick(1);
    chk("t6_epc", EPC, 32'h0000_0777);
    chk("t6_exc_pcj", PC_jmpValue, 32'h0000_0100);
    tick(1);
    interrupt = 1'b0;
    tick(1);

    // Reset mid-PUSH_LO aborts; a later interrupt runs cleanly
    interrupt = 1'b1;
    tick(6);
    chk("t1_in_push_lo", {16'h0, push_data}, 32'h0040);
    reset = 1'b0; interrupt = 1'b0;
    tick(1);
    chk("t1_push", {31'b0, push_req}, 32'h0);
    chk("t1_data", {16'h0, push_data}, 32'h0);
    chk("t1_stall", {31'b0, stall}, 32'h0);
    chk("t1_busy", {31'b0, busy}, 32'h0);
    chk("t1_epc", EPC, 32'h0);
    chk("t1_pcj", PC_jmpValue, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(1);
    interrupt = 1'b1;
    tick(5);
    chk("t1_re_push_hi", {31'b0, push_req}, 32'h1);
    chk("t1_re_data_hi", {16'h0, push_data}, 32'h0000);
    tick(1);
    chk("t1_re_data_lo", {16'h0, push_data}, 32'h0040);
    tick(3);
    chk("t1_re_jmp", {31'b0, jmp_sgn}, 32'h1);
    chk("t1_re_pcj", PC_jmpValue, 32'h0000_0200);
    tick(1);
    chk("t1_re_idle", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
